// File: rtl/vu_vmu_srq_arbiter_pkg.sv
// Shared field widths, packed request layout and arbiter state encodings
// for the vector memory unit store-request arbiter.
package vu_vmu_srq_arbiter_pkg;

    localparam int SRQ_ADDR_W  = 30;
    localparam int SRQ_TAG_W   = 12;
    localparam int SRQ_OP_W    = 4;
    localparam int SRQ_DATA_W  = 64;
    localparam int SRQ_WMASK_W = 8;
    localparam int SRQ_REQ_W   = SRQ_ADDR_W + SRQ_TAG_W + SRQ_OP_W + SRQ_DATA_W + SRQ_WMASK_W;

    localparam int OP_AMO_BIT = 3;

    localparam logic RR_VS = 1'b0;
    localparam logic RR_UT = 1'b1;

    typedef struct packed {
        logic [SRQ_ADDR_W-1:0]  addr;
        logic [SRQ_TAG_W-1:0]   tag;
        logic [SRQ_OP_W-1:0]    op;
        logic [SRQ_DATA_W-1:0]  data;
        logic [SRQ_WMASK_W-1:0] wmask;
    } srq_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LOCK_VS = 2'd1,
        ARB_LOCK_UT = 2'd2
    } arb_state_e;

    function automatic logic is_amo(input logic [SRQ_OP_W-1:0] op);
        return op[OP_AMO_BIT];
    endfunction

endpackage

// File: rtl/vu_vmu_srq_buf2.sv
// Two-entry FIFO of packed store requests; enq_rdy depends only on the
// registered occupancy so the memory side never reaches the producers.
module vu_vmu_srq_buf2
    import vu_vmu_srq_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enq_val_i,
    output logic                 enq_rdy_o,
    input  logic [SRQ_REQ_W-1:0] enq_bits_i,
    output logic                 deq_val_o,
    input  logic                 deq_rdy_i,
    output logic [SRQ_REQ_W-1:0] deq_bits_o
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [SRQ_REQ_W-1:0] mem_q [2];
    logic [1:0]           count_q;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic                 enq;
    logic                 deq;

    assign enq_rdy_o  = (count_q < FULL_CNT);
    assign deq_val_o  = (count_q != 2'd0);
    assign enq        = enq_val_i & enq_rdy_o;
    assign deq        = deq_val_o & deq_rdy_i;
    assign deq_bits_o = mem_q[rd_ptr_q];

    // Storage is cleared on reset so the request outputs read zero while held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (enq) begin
                mem_q[wr_ptr_q] <= enq_bits_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vu_vmu_srq_arbiter.sv
// Round-robin store-request arbiter between the vector store and UT store/AMO
// producers, with burst locking and a registered 2-entry output buffer.
module vu_vmu_srq_arbiter
    import vu_vmu_srq_arbiter_pkg::*;
#(
    parameter int unsigned BURST_MAX = 8,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [29:0] vs_addr_bits,
    input  logic [11:0] vs_tag_bits,
    input  logic [3:0]  vs_op_bits,
    input  logic [63:0] vs_data_bits,
    input  logic [7:0]  vs_wmask_bits,
    input  logic        vs_val,
    output logic        vs_rdy,

    input  logic [29:0] ut_addr_bits,
    input  logic [11:0] ut_tag_bits,
    input  logic [3:0]  ut_op_bits,
    input  logic [63:0] ut_data_bits,
    input  logic [7:0]  ut_wmask_bits,
    input  logic        ut_val,
    output logic        ut_rdy,

    output logic [29:0] srq_addr_bits,
    output logic [11:0] srq_tag_bits,
    output logic [3:0]  srq_op_bits,
    output logic [63:0] srq_data_bits,
    output logic [7:0]  srq_wmask_bits,
    output logic        srq_val,
    input  logic        srq_rdy,

    output logic        arb_busy
);

    localparam logic [7:0] BURST_LAST  = 8'(BURST_MAX);
    localparam logic       SINGLE_BEAT = (BURST_MAX == 1);

    arb_state_e state_q;
    logic       rr_ptr_q;
    logic [7:0] burst_cnt_q;
    logic       live_q;

    srq_req_t   vs_req;
    srq_req_t   ut_req;
    srq_req_t   enq_req;
    srq_req_t   head_req;

    logic       space;
    logic       grant_vs;
    logic       grant_ut;
    logic       acc_vs;
    logic       acc_ut;
    logic       acc;
    logic       acc_amo;
    logic       owner_ut;
    logic       owner_val;
    logic       other_val;
    logic [7:0] cnt_inc;

    assign vs_req  = '{addr: vs_addr_bits, tag: vs_tag_bits, op: vs_op_bits,
                       data: vs_data_bits, wmask: vs_wmask_bits};
    assign ut_req  = '{addr: ut_addr_bits, tag: ut_tag_bits, op: ut_op_bits,
                       data: ut_data_bits, wmask: ut_wmask_bits};

    always_comb begin
        grant_vs = 1'b0;
        grant_ut = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                grant_vs = vs_val & (~ut_val | (rr_ptr_q == RR_VS));
                grant_ut = ut_val & (~vs_val | (rr_ptr_q == RR_UT));
            end
            ARB_LOCK_VS: grant_vs = vs_val;
            ARB_LOCK_UT: grant_ut = ut_val;
            default: ;
        endcase
    end

    // live_q keeps both rdys low until the first edge after reset release.
    assign vs_rdy    = grant_vs & space & live_q;
    assign ut_rdy    = grant_ut & space & live_q;
    assign acc_vs    = vs_val & vs_rdy;
    assign acc_ut    = ut_val & ut_rdy;
    assign acc       = acc_vs | acc_ut;
    assign enq_req   = acc_ut ? ut_req : vs_req;
    assign acc_amo   = is_amo(enq_req.op);
    assign owner_ut  = (state_q == ARB_LOCK_UT);
    assign owner_val = owner_ut ? ut_val : vs_val;
    assign other_val = owner_ut ? vs_val : ut_val;
    assign cnt_inc   = burst_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= RR_VS;
            burst_cnt_q <= 8'd0;
            live_q      <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                ARB_IDLE: begin
                    if (acc) begin
                        if (acc_amo || SINGLE_BEAT) begin
                            rr_ptr_q <= acc_ut ? RR_VS : RR_UT;
                        end else begin
                            state_q     <= acc_ut ? ARB_LOCK_UT : ARB_LOCK_VS;
                            burst_cnt_q <= 8'd1;
                        end
                    end
                end
                ARB_LOCK_VS, ARB_LOCK_UT: begin
                    if (!owner_val) begin
                        state_q     <= ARB_IDLE;
                        burst_cnt_q <= 8'd0;
                        if (other_val) begin
                            rr_ptr_q <= owner_ut ? RR_VS : RR_UT;
                        end
                    end else if (acc) begin
                        if (acc_amo || (cnt_inc == BURST_LAST)) begin
                            state_q     <= ARB_IDLE;
                            burst_cnt_q <= 8'd0;
                            rr_ptr_q    <= owner_ut ? RR_VS : RR_UT;
                        end else begin
                            burst_cnt_q <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    burst_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    vu_vmu_srq_buf2 #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .enq_val_i  (acc),
        .enq_rdy_o  (space),
        .enq_bits_i (enq_req),
        .deq_val_o  (srq_val),
        .deq_rdy_i  (srq_rdy),
        .deq_bits_o (head_req)
    );

    assign srq_addr_bits  = head_req.addr;
    assign srq_tag_bits   = head_req.tag;
    assign srq_op_bits    = head_req.op;
    assign srq_data_bits  = head_req.data;
    assign srq_wmask_bits = head_req.wmask;

    assign arb_busy = srq_val | (state_q != ARB_IDLE) | vs_val | ut_val;

endmodule
